bcd_display_scanner: RTL and testbench

BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

---
 rtl/bcd_display_scanner.sv | 176 +++++++++++++++++
 tb/tb_bcd_display_scanner.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scanner.sv
// Multiplexed 4-digit BCD display driver: double-buffered value capture,
// time-multiplexed digit scan, leading-zero blanking and minus-sign placement.
module bcd_display_scanner #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LZ    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  output logic        ready,
  input  logic [15:0] digits,
  input  logic        neg,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done,
  output logic        sign_lost,
  output logic        err
);

  localparam int             CW    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]  TC    = CW'(REFRESH_DIV - 1);
  localparam bit             LZ_EN = (BLANK_LZ != 0);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;

  // Pending buffer occupancy. ready = EMPTY; a load is accepted only when
  // ready=1 and the buffer drains into the active register at a frame boundary.
  typedef enum logic {
    PEND_EMPTY = 1'b0,
    PEND_FULL  = 1'b1
  } pend_state_t;

  pend_state_t   r_pend_state;
  pend_state_t   w_pend_next;
  logic          w_capture;
  logic          w_transfer;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_pend_digits;
  logic          r_pend_neg;
  logic [15:0]   r_act_digits;
  logic          r_act_neg;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_frame_done;
  logic          r_sign_lost;
  logic          r_err;

  logic          w_tc;
  logic          w_boundary;
  logic [1:0]    w_msd;
  logic          w_nonzero;
  logic [3:0]    w_nib;
  logic          w_lz_blank;
  logic          w_minus;
  logic [6:0]    w_seg_next;

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    case (n)
      4'd0:    seg_code = 7'b0000001;
      4'd1:    seg_code = 7'b1001111;
      4'd2:    seg_code = 7'b0010010;
      4'd3:    seg_code = 7'b0000110;
      4'd4:    seg_code = 7'b1001100;
      4'd5:    seg_code = 7'b0100100;
      4'd6:    seg_code = 7'b0100000;
      4'd7:    seg_code = 7'b0001111;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0000100;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  // Highest position holding a nonzero nibble (invalid nibbles count as nonzero).
  function automatic logic [1:0] msd_pos(input logic [15:0] d);
    msd_pos = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (d[4*i +: 4] != 4'd0) msd_pos = 2'(i);
    end
  endfunction

  function automatic logic has_invalid(input logic [15:0] d);
    has_invalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (d[4*i +: 4] > 4'd9) has_invalid = 1'b1;
    end
  endfunction

  function automatic logic sign_lost_of(input logic [15:0] d, input logic n);
    sign_lost_of = n && (d != 16'd0) && ((msd_pos(d) == 2'd3) || !LZ_EN);
  endfunction

  assign w_tc       = (r_cnt == TC);
  assign w_boundary = w_tc && (r_idx == 2'd3);

  always_comb begin
    w_pend_next = r_pend_state;
    w_capture   = 1'b0;
    w_transfer  = 1'b0;
    case (r_pend_state)
      PEND_EMPTY: begin
        if (load) begin
          w_capture   = 1'b1;
          w_pend_next = PEND_FULL;
        end
      end
      PEND_FULL: begin
        if (w_boundary) begin
          w_transfer  = 1'b1;
          w_pend_next = PEND_EMPTY;
        end
      end
      default: w_pend_next = PEND_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_pend_state <= PEND_EMPTY;
    else     r_pend_state <= w_pend_next;
  end

  // Segment pattern for the position currently selected by r_idx.
  always_comb begin
    w_msd      = msd_pos(r_act_digits);
    w_nonzero  = (r_act_digits != 16'd0);
    w_nib      = r_act_digits[{r_idx, 2'b00} +: 4];
    w_lz_blank = LZ_EN && (r_idx > w_msd);
    w_minus    = LZ_EN && r_act_neg && w_nonzero && (w_msd != 2'd3) &&
                 (r_idx == w_msd + 2'd1);
    w_seg_next = seg_code(w_nib);
    if (w_minus)         w_seg_next = SEG_MINUS;
    else if (w_lz_blank) w_seg_next = SEG_BLANK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_idx         <= 2'd0;
      r_pend_digits <= 16'd0;
      r_pend_neg    <= 1'b0;
      r_act_digits  <= 16'd0;
      r_act_neg     <= 1'b0;
      r_an          <= 4'b1111;
      r_seg         <= SEG_BLANK;
      r_frame_done  <= 1'b0;
      r_sign_lost   <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_cnt        <= w_tc ? '0 : r_cnt + 1'b1;
      if (w_tc) r_idx <= r_idx + 2'd1;
      r_frame_done <= w_boundary;
      r_an         <= ~(4'b0001 << r_idx);
      r_seg        <= w_seg_next;
      if (w_capture) begin
        r_pend_digits <= digits;
        r_pend_neg    <= neg;
        if (has_invalid(digits)) r_err <= 1'b1;
      end
      if (w_transfer) begin
        r_act_digits <= r_pend_digits;
        r_act_neg    <= r_pend_neg;
        r_sign_lost  <= sign_lost_of(r_pend_digits, r_pend_neg);
      end
    end
  end

  assign ready      = (r_pend_state == PEND_EMPTY);
  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_done = r_frame_done;
  assign sign_lost  = r_sign_lost;
  assign err        = r_err;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with REFRESH_DIV=4 (16-cycle frame).
module tb_bcd_display_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        ready;
  logic [15:0] digits = 16'd0;
  logic        neg = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;
  logic        sign_lost;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] MI = 7'b1111110;

  bcd_display_scanner #(.REFRESH_DIV(4), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .load(load), .ready(ready), .digits(digits),
    .neg(neg), .seg(seg), .an(an), .frame_done(frame_done),
    .sign_lost(sign_lost), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic n);
    load   = 1'b1;
    digits = d;
    neg    = n;
    step(1);
    load   = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int k;
    k = 0;
    while (frame_done !== 1'b1 && k < 40) begin
      step(1);
      k++;
    end
    chk({tag, "_frame_seen"}, {15'd0, frame_done}, 16'd1);
  endtask

  // Starts on a frame_done cycle; checks positions 0..3, ends on the next frame_done.
  task automatic show_frame(input string tag, input logic [6:0] p0, input logic [6:0] p1,
                            input logic [6:0] p2, input logic [6:0] p3);
    logic [6:0] exp_seg [4];
    exp_seg[0] = p0; exp_seg[1] = p1; exp_seg[2] = p2; exp_seg[3] = p3;
    for (int p = 0; p < 4; p++) begin
      step(p == 0 ? 1 : 4);
      chk($sformatf("%s_an%0d", tag, p), {12'd0, an}, {12'd0, ~(4'b0001 << p)});
      chk($sformatf("%s_seg%0d", tag, p), {9'd0, seg}, {9'd0, exp_seg[p]});
      if (p == 0) chk({tag, "_fd_low"}, {15'd0, frame_done}, 16'd0);
    end
    step(3);
    chk({tag, "_fd_period"}, {15'd0, frame_done}, 16'd1);
  endtask

  initial begin
    // Reset
    step(2);
    chk("rst_an", {12'd0, an}, 16'h000f);
    chk("rst_seg", {9'd0, seg}, {9'd0, BL});
    chk("rst_ready", {15'd0, ready}, 16'd1);
    chk("rst_err", {15'd0, err}, 16'd0);
    chk("rst_fd", {15'd0, frame_done}, 16'd0);
    chk("rst_sl", {15'd0, sign_lost}, 16'd0);
    rst = 1'b0;
    step(1);
    chk("post_rst_an", {12'd0, an}, 16'h000e);
    chk("post_rst_seg", {9'd0, seg}, 16'h0001);

    // Basic display of 6
    do_load(16'h0006, 1'b0);
    chk("load6_ready_low", {15'd0, ready}, 16'd0);
    wait_frame("load6");
    chk("load6_ready_high", {15'd0, ready}, 16'd1);
    show_frame("v6", 7'b0100000, BL, BL, BL);
    chk("v6_sl", {15'd0, sign_lost}, 16'd0);

    // Minus placement for -3
    do_load(16'h0003, 1'b1);
    wait_frame("neg3");
    show_frame("vm3", 7'b0000110, MI, BL, BL);
    chk("vm3_sl", {15'd0, sign_lost}, 16'd0);

    // No room for minus with -1234
    do_load(16'h1234, 1'b1);
    wait_frame("neg1234");
    chk("v1234_sl", {15'd0, sign_lost}, 16'd1);
    show_frame("v1234", 7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111);

    // Invalid nibble and sticky err
    do_load(16'h00a5, 1'b0);
    chk("a5_err_set", {15'd0, err}, 16'd1);
    wait_frame("a5");
    chk("a5_sl_clear", {15'd0, sign_lost}, 16'd0);
    show_frame("va5", 7'b0100100, BL, BL, BL);
    do_load(16'h0001, 1'b0);
    wait_frame("one");
    show_frame("v1", 7'b1001111, BL, BL, BL);
    chk("err_sticky", {15'd0, err}, 16'd1);

    // Load on the boundary cycle, then an ignored load while ready=0
    step(15);
    do_load(16'h0042, 1'b0);
    chk("bnd_fd", {15'd0, frame_done}, 16'd1);
    chk("bnd_ready_low", {15'd0, ready}, 16'd0);
    step(1);
    chk("bnd_old_value", {9'd0, seg}, 16'h004f);
    do_load(16'h0099, 1'b0);
    wait_frame("bnd");
    show_frame("v42", 7'b0010010, 7'b1001100, BL, BL);
    chk("v42_ready", {15'd0, ready}, 16'd1);

    // Reset at index 2 with pending full
    do_load(16'h0500, 1'b1);
    chk("mid_ready_low", {15'd0, ready}, 16'd0);
    step(8);
    chk("mid_an_idx2", {12'd0, an}, 16'h000b);
    rst = 1'b1;
    step(1);
    chk("mid_rst_an", {12'd0, an}, 16'h000f);
    chk("mid_rst_seg", {9'd0, seg}, {9'd0, BL});
    chk("mid_rst_ready", {15'd0, ready}, 16'd1);
    chk("mid_rst_err", {15'd0, err}, 16'd0);
    chk("mid_rst_fd", {15'd0, frame_done}, 16'd0);
    rst = 1'b0;
    step(1);
    chk("mid_post_an", {12'd0, an}, 16'h000e);
    chk("mid_post_seg", {9'd0, seg}, 16'h0001);
    wait_frame("mid");
    chk("mid_pending_dropped", {15'd0, ready}, 16'd1);
    show_frame("v0", 7'b0000001, BL, BL, BL);
    chk("v0_sl", {15'd0, sign_lost}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
